// File: rtl/isa_pkg.sv
// ----------------------------------------------------------------------------
// isa_pkg
//
// Shared definitions for the ISA instruction FIFO path. The issuer on the
// transmit side and the accelerator dispatcher on the receive side both use it.
//
// Contents:
//   ISA, ADDR             field widths of one ISA FIFO entry {op, addr}
//   LEN_W                 width of the host command length field (words)
//   RD_BURST / WR_BURST   default words carried by one read / write entry
//   WORD_BYTES            byte stride of one word
//   OP_*                  opcode encodings
//   isa_state_e           issuer FSM state encoding
//   isa_op_legal()        true for opcodes that may be turned into entries
// ----------------------------------------------------------------------------
package isa_pkg;

  localparam int ISA        = 2;
  localparam int ADDR       = 32;
  localparam int LEN_W      = 16;
  localparam int RD_BURST   = 8;
  localparam int WR_BURST   = 16;
  localparam int WORD_BYTES = 4;

  localparam logic [ISA-1:0] OP_NOP   = 2'b00;
  localparam logic [ISA-1:0] OP_READ  = 2'b01;
  localparam logic [ISA-1:0] OP_WRITE = 2'b10;
  localparam logic [ISA-1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } isa_state_e;

  // Only read and write produce FIFO entries; NOP and the reserved code are
  // rejected at the command interface.
  function automatic logic isa_op_legal(input logic [ISA-1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/isa_cmd_issuer.sv
// ----------------------------------------------------------------------------
// isa_cmd_issuer
//
// Transmit side of the ISA instruction FIFO. Accepts one host transfer command
// (opcode, byte base address, length in words) and splits it into per-burst
// ISA entries {opcode, addr}. Entries are written into the ISA FIFO while its
// full flag is low; a full FIFO stalls the issuer indefinitely with every
// register held.
//
// Reads use RD_BURST words per entry, writes WR_BURST words per entry. A
// command produces ceil(cmd_len / burst) entries; a short final burst is still
// issued as a full entry. Addresses advance by burst*WORD_BYTES and wrap
// silently at 2^ADDR.
//
// Optional build macro:
//   ISA_ALIGN_CHECK_EN  when defined, a command whose cmd_addr[1:0] != 0 is
//                       rejected exactly like an illegal opcode. When not
//                       defined, the address is taken as given and its low
//                       bits are carried into every entry.
//
// Handshake (command side): a command transfers on a cycle where
// cmd_valid && cmd_ready. cmd_ready is high only in IDLE (and low during reset
// and the first cycle after it). The host holds cmd_valid and the command
// fields until that cycle; cmd_valid seen while cmd_ready is low is ignored.
// FIFO side: ISA_FIFO_wr_en is a write strobe qualified by !ISA_FIFO_full, so
// every cycle with wr_en high is one accepted entry.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   cmd_valid        host command present
//   cmd_ready        issuer can accept a command
//   cmd_op           01 read, 10 write, 00/11 illegal
//   cmd_addr         byte base address
//   cmd_len          transfer length in words
//   ISA_FIFO_full    ISA FIFO full flag
//   ISA_FIFO_din     entry {op, addr}
//   ISA_FIFO_wr_en   FIFO write strobe
//   busy             command in progress (ISSUE state)
//   done             one-cycle pulse: command complete
//   err_illegal      one-cycle pulse: command rejected
//   issued_count     running total of entries written, wraps at 2^16
//   dbg_state        current FSM state (isa_state_e encoding)
// ----------------------------------------------------------------------------
module isa_cmd_issuer
  import isa_pkg::*;
#(
  parameter int LEN_W      = isa_pkg::LEN_W,
  parameter int RD_BURST   = isa_pkg::RD_BURST,
  parameter int WR_BURST   = isa_pkg::WR_BURST,
  parameter int WORD_BYTES = isa_pkg::WORD_BYTES
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ISA-1:0]      cmd_op,
  input  logic [ADDR-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,

  input  logic                ISA_FIFO_full,
  output logic [ISA+ADDR-1:0] ISA_FIFO_din,
  output logic                ISA_FIFO_wr_en,

  output logic                busy,
  output logic                done,
  output logic                err_illegal,
  output logic [15:0]         issued_count,
  output logic [1:0]          dbg_state
);

  isa_state_e        state;

  // Latched command context, advanced once per accepted entry.
  logic [ISA-1:0]    op_r;
  logic [ADDR-1:0]   addr_r;
  logic [LEN_W-1:0]  rem_r;
  logic [LEN_W-1:0]  burst_r;

  logic              cmd_fire;
  logic              cmd_reject;
  logic [LEN_W-1:0]  cmd_burst;
  logic [ADDR-1:0]   addr_stride;
  logic [LEN_W-1:0]  rem_next;
  logic              last_entry;

  assign cmd_fire = cmd_valid && cmd_ready;

`ifdef ISA_ALIGN_CHECK_EN
  // Word-unaligned base addresses are refused up front so that no entry ever
  // carries stray byte-offset bits.
  assign cmd_reject = !isa_op_legal(cmd_op) || (cmd_addr[1:0] != 2'b00);
`else
  assign cmd_reject = !isa_op_legal(cmd_op);
`endif

  assign cmd_burst = (cmd_op == OP_READ) ? LEN_W'(RD_BURST) : LEN_W'(WR_BURST);

  // Byte distance between consecutive entries; the add below is modulo 2^ADDR.
  assign addr_stride = ADDR'(burst_r) * ADDR'(WORD_BYTES);

  // Remaining words saturate at zero so a short final burst cannot underflow.
  assign rem_next   = (rem_r > burst_r) ? (rem_r - burst_r) : '0;
  assign last_entry = (rem_r <= burst_r);

  // The entry and its strobe come straight from registers and the full flag,
  // so a stalled entry stays on din unchanged until the FIFO takes it.
  assign ISA_FIFO_din   = {op_r, addr_r};
  assign ISA_FIFO_wr_en = (state == ST_ISSUE) && !ISA_FIFO_full;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_illegal  <= 1'b0;
      op_r         <= '0;
      addr_r       <= '0;
      rem_r        <= '0;
      burst_r      <= '0;
      issued_count <= '0;
    end else begin
      // Both status strobes are single-cycle pulses unless re-armed below.
      done        <= 1'b0;
      err_illegal <= 1'b0;

      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            if (cmd_reject) begin
              // Rejected commands leave the latched context untouched and
              // keep the interface open for the next command.
              err_illegal <= 1'b1;
            end else begin
              op_r      <= cmd_op;
              addr_r    <= cmd_addr;
              rem_r     <= cmd_len;
              burst_r   <= cmd_burst;
              cmd_ready <= 1'b0;
              if (cmd_len == '0) begin
                // Nothing to issue: complete immediately.
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_ISSUE;
                busy  <= 1'b1;
              end
            end
          end
        end

        ST_ISSUE: begin
          cmd_ready <= 1'b0;
          if (ISA_FIFO_wr_en) begin
            addr_r       <= addr_r + addr_stride;
            rem_r        <= rem_next;
            issued_count <= issued_count + 16'd1;
            if (last_entry) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // done is high during this state; cmd_ready follows one cycle later.
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isa_cmd_issuer.sv
// ----------------------------------------------------------------------------
// tb_isa_cmd_issuer
//
// Directed bench for isa_cmd_issuer. Inputs change 1 ns after the rising edge;
// registered outputs are checked at that point, and FIFO writes are collected
// on the falling edge and matched against an expected-entry queue. Compile
// with +define+ISA_ALIGN_CHECK_EN to cover the alignment-reject build.
// ----------------------------------------------------------------------------
module tb_isa_cmd_issuer;

  localparam int W = 34;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  always #5 clk = ~clk;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_addr;
  logic [15:0]   cmd_len;
  logic          fifo_full;
  logic [W-1:0]  fifo_din;
  logic          fifo_wr_en;
  logic          busy;
  logic          done;
  logic          err_illegal;
  logic [15:0]   issued_count;
  logic [1:0]    dbg_state;

  isa_cmd_issuer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .ISA_FIFO_full  (fifo_full),
    .ISA_FIFO_din   (fifo_din),
    .ISA_FIFO_wr_en (fifo_wr_en),
    .busy           (busy),
    .done           (done),
    .err_illegal    (err_illegal),
    .issued_count   (issued_count),
    .dbg_state      (dbg_state)
  );

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [15:0] exp_issued = 16'd0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_entry(input logic [1:0] op, input logic [31:0] a);
    exp_q.push_back({op, a});
    exp_issued = exp_issued + 16'd1;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_write: observed %0h expected no write", fifo_din);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        chk("fifo_entry", 64'(fifo_din), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [15:0] l);
    chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Checks one write cycle (strobe and entry) and then advances a cycle.
  task automatic expect_write(input string tag, input logic [1:0] op, input logic [31:0] a);
    chk({tag, "_wr_en"}, 64'(fifo_wr_en), 64'd1);
    chk({tag, "_din"}, 64'(fifo_din), 64'({op, a}));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    tick();
  endtask

  // Checks the DONE cycle and the IDLE cycle after it.
  task automatic expect_done(input string tag);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_done_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done_ready"}, 64'(cmd_ready), 64'd0);
    chk({tag, "_done_wr_en"}, 64'(fifo_wr_en), 64'd0);
    chk({tag, "_issued"}, 64'(issued_count), 64'(exp_issued));
    exp_done++;
    tick();
    chk({tag, "_done_drop"}, 64'(done), 64'd0);
    chk({tag, "_ready_back"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_idle"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 32'h0;
    cmd_len   = 16'h0;
    fifo_full = 1'b0;
    tick();
    tick();

    // Reset values
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_din", 64'(fifo_din), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_illegal), 64'd0);
    chk("rst_issued", 64'(issued_count), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Read 0x1000, 20 words -> three 8-word entries back to back
    push_entry(2'b01, 32'h00001000);
    push_entry(2'b01, 32'h00001020);
    push_entry(2'b01, 32'h00001040);
    send(2'b01, 32'h00001000, 16'd20);
    chk("rd_state_issue", 64'(dbg_state), 64'(S_ISSUE));
    chk("rd_ready_low", 64'(cmd_ready), 64'd0);
    expect_write("rd0", 2'b01, 32'h00001000);
    expect_write("rd1", 2'b01, 32'h00001020);
    expect_write("rd2", 2'b01, 32'h00001040);
    expect_done("rd");

    // Write 0x2000, 16 words -> one entry
    push_entry(2'b10, 32'h00002000);
    send(2'b10, 32'h00002000, 16'd16);
    expect_write("wr0", 2'b10, 32'h00002000);
    expect_done("wr");

    // Read 0x0, 32 words with a 3-cycle stall after the second entry
    push_entry(2'b01, 32'h00000000);
    push_entry(2'b01, 32'h00000020);
    push_entry(2'b01, 32'h00000040);
    push_entry(2'b01, 32'h00000060);
    send(2'b01, 32'h00000000, 16'd32);
    expect_write("st0", 2'b01, 32'h00000000);
    expect_write("st1", 2'b01, 32'h00000020);
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_wr_en", 64'(fifo_wr_en), 64'd0);
      chk("stall_din", 64'(fifo_din), 64'({2'b01, 32'h00000040}));
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_issued", 64'(issued_count), 64'd6);
      tick();
    end
    fifo_full = 1'b0;
    #1;
    expect_write("st2", 2'b01, 32'h00000040);
    expect_write("st3", 2'b01, 32'h00000060);
    expect_done("st");

    // Reserved opcode -> reject pulse, nothing written
    send(2'b11, 32'h00003000, 16'd8);
    chk("ill_err", 64'(err_illegal), 64'd1);
    chk("ill_busy", 64'(busy), 64'd0);
    chk("ill_state", 64'(dbg_state), 64'(S_IDLE));
    chk("ill_wr_en", 64'(fifo_wr_en), 64'd0);
    tick();
    chk("ill_err_drop", 64'(err_illegal), 64'd0);
    chk("ill_issued", 64'(issued_count), 64'(exp_issued));

    // Unaligned base address
`ifdef ISA_ALIGN_CHECK_EN
    send(2'b01, 32'h00001002, 16'd8);
    chk("ual_err", 64'(err_illegal), 64'd1);
    chk("ual_busy", 64'(busy), 64'd0);
    chk("ual_wr_en", 64'(fifo_wr_en), 64'd0);
    tick();
    chk("ual_err_drop", 64'(err_illegal), 64'd0);
`else
    push_entry(2'b01, 32'h00001002);
    send(2'b01, 32'h00001002, 16'd8);
    chk("ual_err", 64'(err_illegal), 64'd0);
    expect_write("ual0", 2'b01, 32'h00001002);
    expect_done("ual");
`endif

    // Address wrap at 2^32
    push_entry(2'b01, 32'hFFFFFFE0);
    push_entry(2'b01, 32'h00000000);
    send(2'b01, 32'hFFFFFFE0, 16'd16);
    expect_write("wrap0", 2'b01, 32'hFFFFFFE0);
    expect_write("wrap1", 2'b01, 32'h00000000);
    expect_done("wrap");

    // Zero length -> straight to DONE
    send(2'b01, 32'h00004000, 16'd0);
    chk("len0_state", 64'(dbg_state), 64'(S_DONE));
    expect_done("len0");

    // Reset in the middle of a 64-word read
    push_entry(2'b01, 32'h00005000);
    push_entry(2'b01, 32'h00005020);
    push_entry(2'b01, 32'h00005040);
    send(2'b01, 32'h00005000, 16'd64);
    expect_write("rr0", 2'b01, 32'h00005000);
    expect_write("rr1", 2'b01, 32'h00005020);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rr_state", 64'(dbg_state), 64'(S_IDLE));
    chk("rr_issued", 64'(issued_count), 64'd0);
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_done", 64'(done), 64'd0);
    tick();
    chk("rr_ready", 64'(cmd_ready), 64'd1);
    tick();
    tick();
    chk("rr_still_idle", 64'(dbg_state), 64'(S_IDLE));

    // End-of-run scoreboard checks
    chk("done_pulses", 64'(done_cnt), 64'(exp_done));
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
